updown_toggle_counter: RTL and testbench

UPDOWN_TOGGLE_COUNTER -- requirements
Module: updown_toggle_counter

---
 rtl/updown_toggle_counter_if.sv | 23 ++
 rtl/updown_toggle_counter.sv | 127 ++++++++++++
 tb/tb_updown_toggle_counter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/updown_toggle_counter_if.sv
// Signal bundle for updown_toggle_counter: the two toggle request levels in,
// and the registered count and event pulses out.
interface updown_toggle_counter_if #(
  parameter int WIDTH = 4
);
  logic             plus_toggle;
  logic             minus_toggle;
  logic [WIDTH-1:0] count;
  logic             up_pulse;
  logic             down_pulse;
  logic             carry;
  logic             borrow;

  modport master (
    output plus_toggle, minus_toggle,
    input  count, up_pulse, down_pulse, carry, borrow
  );

  modport slave (
    input  plus_toggle, minus_toggle,
    output count, up_pulse, down_pulse, carry, borrow
  );
endinterface

// File: rtl/updown_toggle_counter.sv
// Up/down counter driven by level-toggle requests from another clock domain.
// Define UPDOWN_SATURATE_EN to saturate at 0/MAXVAL instead of wrapping.
//
// state    | meaning
// DISARMED | reset just released; events discarded
// ARM1     | synchronizers still filling; events discarded
// ARMED    | normal operation until the next reset
module updown_toggle_counter #(
  parameter int WIDTH  = 4,
  parameter int MAXVAL = 9
) (
  input  logic clk,
  input  logic rst_n,
  updown_toggle_counter_if.slave bus
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARM1     = 2'd1,
    ARMED    = 2'd2
  } arm_state_t;

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAXVAL);
`ifdef UPDOWN_SATURATE_EN
  localparam logic [WIDTH-1:0] C_AFTER_MAX  = C_MAX;
  localparam logic [WIDTH-1:0] C_AFTER_ZERO = '0;
`else
  localparam logic [WIDTH-1:0] C_AFTER_MAX  = '0;
  localparam logic [WIDTH-1:0] C_AFTER_ZERO = C_MAX;
`endif

  logic [1:0]       r_plus_sync;
  logic [1:0]       r_minus_sync;
  logic             r_plus_prev;
  logic             r_minus_prev;
  logic             r_released;
  arm_state_t       r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_up;
  logic             r_down;
  logic             r_carry;
  logic             r_borrow;

  arm_state_t       w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_up;
  logic             w_down;
  logic             w_carry;
  logic             w_borrow;
  logic             w_plus_evt;
  logic             w_minus_evt;

  assign w_plus_evt  = r_plus_sync[1]  ^ r_plus_prev;
  assign w_minus_evt = r_minus_sync[1] ^ r_minus_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_plus_sync  <= '0;
      r_minus_sync <= '0;
      r_plus_prev  <= 1'b0;
      r_minus_prev <= 1'b0;
      r_released   <= 1'b0;
      r_state      <= DISARMED;
      r_count      <= '0;
      r_up         <= 1'b0;
      r_down       <= 1'b0;
      r_carry      <= 1'b0;
      r_borrow     <= 1'b0;
    end else begin
      r_plus_sync  <= {r_plus_sync[0], bus.plus_toggle};
      r_minus_sync <= {r_minus_sync[0], bus.minus_toggle};
      r_plus_prev  <= r_plus_sync[1];
      r_minus_prev <= r_minus_sync[1];
      r_released   <= 1'b1;
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_up         <= w_up;
      r_down       <= w_down;
      r_carry      <= w_carry;
      r_borrow     <= w_borrow;
    end
  end

  // The first edge after release only notes that reset is gone, so the
  // arm window spans the cycle in which a level already held high during
  // reset emerges from the synchronizer as a spurious event.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_up        = 1'b0;
    w_down      = 1'b0;
    w_carry     = 1'b0;
    w_borrow    = 1'b0;
    case (r_state)
      DISARMED: if (r_released) w_state_nxt = ARM1;
      ARM1:     w_state_nxt = ARMED;
      ARMED: begin
        w_state_nxt = ARMED;
        if (w_plus_evt && !w_minus_evt) begin
          w_up = 1'b1;
          if (r_count == C_MAX) begin
            w_carry     = 1'b1;
            w_count_nxt = C_AFTER_MAX;
          end else begin
            w_count_nxt = r_count + WIDTH'(1);
          end
        end else if (w_minus_evt && !w_plus_evt) begin
          w_down = 1'b1;
          if (r_count == '0) begin
            w_borrow    = 1'b1;
            w_count_nxt = C_AFTER_ZERO;
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
      end
      default:  w_state_nxt = DISARMED;
    endcase
  end

  assign bus.count      = r_count;
  assign bus.up_pulse   = r_up;
  assign bus.down_pulse = r_down;
  assign bus.carry      = r_carry;
  assign bus.borrow     = r_borrow;

endmodule

// File: tb/tb_updown_toggle_counter.sv
// Scoreboard bench for updown_toggle_counter: stimulus pushes expected
// per-cycle results, a monitor pops and compares them after each edge.
module tb_updown_toggle_counter;

  localparam int WIDTH  = 4;
  localparam int MAXVAL = 9;
`ifdef UPDOWN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int cyc;
    int count;
    bit up;
    bit down;
    bit carry;
    bit borrow;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   r0 = 0;
  int   errors = 0;
  int   checks = 0;
  int   model_cnt = 0;
  int   mon_cnt = 0;
  bit   lvl_p = 1'b0;
  bit   lvl_m = 1'b0;
  bit   cur_p = 1'b0;
  bit   cur_m = 1'b0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t mon_exp;

  updown_toggle_counter_if #(.WIDTH(WIDTH)) bus ();

  updown_toggle_counter #(.WIDTH(WIDTH), .MAXVAL(MAXVAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A level presented before edge k is seen as an event at edge k+2, and is
  // honoured only when k lies at least two edges past the reset release.
  task automatic step(input bit np, input bit nm);
    int   k;
    bit   ep;
    bit   em;
    exp_t e;
    @(negedge clk);
    cur_p = np;
    cur_m = nm;
    bus.plus_toggle  = np;
    bus.minus_toggle = nm;
    k  = cyc + 1;
    ep = (np != lvl_p);
    em = (nm != lvl_m);
    lvl_p = np;
    lvl_m = nm;
    if (k >= r0 + 2 && ep != em) begin
      e.cyc = k + 2; e.up = ep; e.down = em; e.carry = 1'b0; e.borrow = 1'b0;
      if (ep) begin
        if (model_cnt == MAXVAL) begin
          e.carry = 1'b1;
          model_cnt = SAT ? MAXVAL : 0;
        end else model_cnt++;
      end else begin
        if (model_cnt == 0) begin
          e.borrow = 1'b1;
          model_cnt = SAT ? 0 : MAXVAL;
        end else model_cnt--;
      end
      e.count = model_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(cur_p, cur_m);
  endtask

  task automatic tog_p();
    step(!cur_p, cur_m);
  endtask

  task automatic tog_m();
    step(cur_p, !cur_m);
  endtask

  task automatic drive_to(input int target);
    for (int i = 0; i < 40 && model_cnt != target; i++) begin
      if (model_cnt < target) tog_p();
      else tog_m();
    end
  endtask

  // Reset is held from just after a falling edge until just after the
  // (hold)th following rising edge; outputs must clear immediately.
  task automatic do_reset(input int hold);
    @(negedge clk);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== '0 || {bus.up_pulse, bus.down_pulse, bus.carry, bus.borrow} !== 4'b0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d pulses=%b, required count=0 pulses=0000",
               bus.count, {bus.up_pulse, bus.down_pulse, bus.carry, bus.borrow});
    end
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
    r0 = cyc;
    sb.delete();
    lvl_p = 1'b0;
    lvl_m = 1'b0;
    model_cnt = 0;
    mon_cnt = 0;
    #1 mon_en = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      mon_exp.cyc = cyc; mon_exp.count = mon_cnt;
      mon_exp.up = 1'b0; mon_exp.down = 1'b0; mon_exp.carry = 1'b0; mon_exp.borrow = 1'b0;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL sb_stale: entry for edge %0d still queued at edge %0d", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_exp = sb.pop_front();
        mon_cnt = mon_exp.count;
      end
      checks++;
      if (bus.count !== WIDTH'(mon_exp.count) || bus.up_pulse !== mon_exp.up ||
          bus.down_pulse !== mon_exp.down || bus.carry !== mon_exp.carry ||
          bus.borrow !== mon_exp.borrow) begin
        errors++;
        $display("FAIL edge_%0d: got count=%0d up=%b down=%b carry=%b borrow=%b, required count=%0d up=%b down=%b carry=%b borrow=%b",
                 cyc, bus.count, bus.up_pulse, bus.down_pulse, bus.carry, bus.borrow,
                 mon_exp.count, mon_exp.up, mon_exp.down, mon_exp.carry, mon_exp.borrow);
      end
    end
  end

  initial begin
    bus.minus_toggle = 1'b0;
    bus.plus_toggle  = 1'b1;
    cur_p = 1'b1;
    do_reset(3);
    idle(10);

    for (int i = 0; i < 5; i++) begin
      tog_p();
      idle(3);
    end

    drive_to(MAXVAL);
    idle(2);
    tog_p();
    idle(3);

    drive_to(0);
    idle(2);
    tog_m();
    idle(3);

    drive_to(3);
    idle(2);
    step(!cur_p, !cur_m);
    idle(4);

    drive_to(7);
    idle(3);
    do_reset(1);
    for (int i = 0; i < 6; i++) tog_p();
    idle(3);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 7);
      step(cur_p ^ (r == 1 || r == 3), cur_m ^ (r == 2 || r == 3));
    end

    idle(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
